// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory initiator and the data memory itself.
package mem_access_pkg;

  localparam int unsigned DefAddrW    = 16;
  localparam int unsigned DefDataW    = 16;
  localparam int unsigned DefMemDepth = 128;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for the 16-bit data-memory port.
// Requests are latched in IDLE, the memory strobes fire for exactly one cycle
// in ISSUE, load data is captured in WAIT, and the response is held in RESP
// until it is consumed.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MEM_DEPTH = DefMemDepth
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              in_range;

  // Widen both sides so the compare stays unsigned and never truncates MEM_DEPTH.
  assign in_range = 64'(req_addr) < 64'(MEM_DEPTH);

  // Next-state and response/latch updates.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (in_range) begin
            // Only in-range requests reach the memory port, so mem_addr/mem_wdata
            // keep their last issued value across an error response.
            write_d = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            state_d = StIssue;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StIssue: begin
        if (write_q) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        rdata_d = mem_rdata;
        err_d   = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from flops so they are glitch-free and mutually exclusive.
  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign mem_write = (state_q == StIssue) && write_q;
  assign mem_read  = (state_q == StIssue) && !write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected responses,
// a negedge monitor checks latency, strobes, stability and response payload.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_write, mem_read;
  logic [15:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  int rsp_mode = 0;  // 0: always ready, 1: random, 2: held low

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          wr;
    int          rd;
    logic [15:0] addr;
    logic [15:0] wdata;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .MEM_DEPTH(128)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: synchronous write, read data valid the cycle after mem_read.
  logic [15:0] mem [128];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem_rdata = 16'h0000;
  end
  always @(posedge clk) begin
    if (mem_write && mem_addr < 16'd128) mem[mem_addr[6:0]] <= mem_wdata;
    if (mem_read && mem_addr < 16'd128) mem_rdata <= mem[mem_addr[6:0]];
  end

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endfunction

  // Response-ready driver.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: tracks each accepted request until its response handshake.
  exp_t        cur;
  bit          tracking = 0;
  bit          in_rsp = 0;
  int          cnt, wr_cnt, rd_cnt;
  logic [15:0] hold_rdata;
  logic        hold_err;
  always @(negedge clk) begin
    if (!rst_n) begin
      tracking = 0;
      in_rsp   = 0;
    end else begin
      chk("strobe_exclusive", {31'd0, mem_read && mem_write}, 32'd0);
      if (tracking) begin
        cnt++;
        if (mem_write) wr_cnt++;
        if (mem_read) rd_cnt++;
        if (mem_write || mem_read) chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
        if (mem_write) chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
      end
      if (rsp_valid) begin
        if (!tracking) begin
          chk("rsp_without_req", 32'd1, 32'd0);
        end else if (!in_rsp) begin
          in_rsp     = 1;
          hold_rdata = rsp_rdata;
          hold_err   = rsp_err;
          chk("latency", 32'(cnt), 32'(cur.lat));
        end else begin
          chk("rdata_stable", 32'(rsp_rdata), 32'(hold_rdata));
          chk("err_stable", 32'(rsp_err), 32'(hold_err));
        end
        if (rsp_ready && tracking) begin
          chk("rsp_rdata", 32'(rsp_rdata), 32'(cur.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(cur.err));
          chk("write_strobes", 32'(wr_cnt), 32'(cur.wr));
          chk("read_strobes", 32'(rd_cnt), 32'(cur.rd));
          void'(sb.pop_front());
          tracking = 0;
          in_rsp   = 0;
        end
      end
      if (req_valid && req_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_accept", 32'd1, 32'd0);
        end else begin
          cur      = sb[0];
          tracking = 1;
          cnt      = 0;
          wr_cnt   = 0;
          rd_cnt   = 0;
        end
      end
    end
  end

  // Issue one request; call at posedge+1, returns at posedge+1 after the accept edge.
  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp_rd);
    exp_t e;
    int   n;
    e.err   = (a >= 16'd128);
    e.rdata = (w || e.err) ? 16'h0000 : exp_rd;
    e.lat   = e.err ? 1 : (w ? 2 : 3);
    e.wr    = (!e.err && w) ? 1 : 0;
    e.rd    = (!e.err && !w) ? 1 : 0;
    e.addr  = a;
    e.wdata = d;
    sb.push_back(e);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("response_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  logic [15:0] rnd [8];

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic store then load.
    send(1'b1, 16'h0005, 16'hBEEF, 16'h0000);
    send(1'b0, 16'h0005, 16'h0000, 16'hBEEF);
    wait_idle();

    // Range boundary.
    send(1'b0, 16'h0080, 16'h0000, 16'h0000);
    send(1'b0, 16'hFFFF, 16'h0000, 16'h0000);
    send(1'b1, 16'h007F, 16'h5A5A, 16'h0000);
    send(1'b0, 16'h007F, 16'h0000, 16'h5A5A);
    send(1'b1, 16'h0100, 16'h1234, 16'h0000);
    send(1'b0, 16'h007F, 16'h0000, 16'h5A5A);
    wait_idle();
    chk("oob_store_no_alias", 32'(mem[0]), 32'd0);

    // Stalled response with a second request pending.
    rsp_mode = 2;
    @(posedge clk);
    #1;
    send(1'b0, 16'h0005, 16'h0000, 16'hBEEF);
    fork
      send(1'b1, 16'h0010, 16'h1234, 16'h0000);
      begin
        int n;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("stall_req_ready", 32'(req_ready), 32'd0);
          if (i >= 2) chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_mode = 0;
        n = 0;
        @(negedge clk);
        while (!(rsp_valid && rsp_ready) && n < 20) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        chk("post_stall_ready", 32'(req_ready), 32'd1);
        chk("post_stall_valid", 32'(req_valid), 32'd1);
      end
    join
    wait_idle();
    chk("stall_store_mem", 32'(mem[16]), 32'h1234);

    // Reset during the ISSUE cycle of a store.
    send(1'b1, 16'h0003, 16'h1111, 16'h0000);
    wait_idle();
    send(1'b1, 16'h0003, 16'hDEAD, 16'h0000);
    chk("issue_mem_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("store_aborted", 32'(mem[3]), 32'h1111);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 16'h0003, 16'h0000, 16'h1111);
    wait_idle();

    // Back-to-back store/load pairs with random data and random rsp_ready.
    rsp_mode = 1;
    for (int i = 0; i < 8; i++) begin
      rnd[i] = 16'($urandom);
      send(1'b1, 16'(i), rnd[i], 16'h0000);
      send(1'b0, 16'(i), 16'h0000, rnd[i]);
    end
    wait_idle();
    rsp_mode = 0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the 16-bit data-memory port. Accepts single-word load/store requests from the pipeline over a valid/ready handshake. Drives the memory's address, write-data and read/write strobes for exactly one cycle per access, then returns load data or a store acknowledgement on a valid/ready response channel. Sits between the execute stage and the data memory, so the pipeline never touches the memory strobes directly.

## Interface
Parameters:
- ADDR_W, 16, request/memory address width
- DATA_W, 16, data word width
- MEM_DEPTH, 128, number of implemented words; addresses >= MEM_DEPTH are out of range

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors
- rsp_err  out  1  address out of range, no memory access made
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the mem_read edge

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. Handshake is req_valid && req_ready at a rising edge. It latches write, addr and wdata. If addr >= MEM_DEPTH: rsp_err<=1, rsp_rdata<=0, go to RESP. Otherwise go to ISSUE.
- ISSUE (one cycle): mem_addr/mem_wdata come from the latched request. mem_write=latched write and mem_read=!latched write, decoded from the state flops. A store goes to RESP with rsp_rdata<=0 and rsp_err<=0. A load goes to WAIT.
- WAIT (one cycle): capture mem_rdata into rsp_rdata, rsp_err<=0, go to RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready at an edge, then go to IDLE.
- mem_read and mem_write are never high in the same cycle. Both are 0 outside ISSUE.
- mem_addr/mem_wdata hold their last value outside ISSUE.
- Address comparison is unsigned over the full ADDR_W. There is no wrap-around or truncation.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
- Latency, counted from the accept edge to the first cycle with rsp_valid=1:
  - load: 3 cycles (ISSUE, WAIT, RESP)
  - store: 2 cycles
  - error: 1 cycle
- Throughput: at most one outstanding request.
- req_ready is low from the accept edge until the response handshake edge. There is no request/response overlap.
- rsp_ready held low stalls in RESP indefinitely. No memory activity occurs while stalled.
- req_valid asserted during non-IDLE states is ignored. The requester must hold it and its payload until accepted.
- Reset asserted mid-operation forces the reset values immediately (asynchronous). An in-flight response is discarded.
  - A store whose ISSUE edge had not yet occurred is not performed.
  - A store whose ISSUE edge had already occurred remains in memory.

## Structure
- Shared package mem_access_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - default ADDR_W/DATA_W/MEM_DEPTH constants, shared with the data-memory depth
- Single module; no sub-module is warranted. The range check is one comparator inline in the IDLE accept path.

## Test plan
- After reset release: req_ready=1, rsp_valid=0, mem strobes 0. Store addr 0x0005, data 0xBEEF, rsp_ready=1 → mem_write=1 for exactly one cycle with mem_addr=5, mem_wdata=0xBEEF; rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- Load addr 0x0005 after that store → mem_read=1 for one cycle; rsp_valid 3 cycles after accept with rsp_rdata=0xBEEF.
- Load addr 0x0080 (=MEM_DEPTH) → no mem strobe at any cycle; rsp_valid next cycle, rsp_err=1, rsp_rdata=0. Addr 0x007F → normal access.
- Load with rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata held stable, req_ready=0, a second req_valid is not accepted; after rsp_ready=1, IDLE and the second request is accepted the following edge.
- Assert rst_n=0 during ISSUE of a store to addr 3 (before the edge) → mem_write drops immediately, memory[3] unchanged, all outputs at reset values.
- Back-to-back: 8 alternating store/load pairs to addresses 0..7 with random data, rsp_ready random → every load returns the matching stored word; mem_read and mem_write never high together.
